// File: rtl/reg_file_pkg.sv
// ============================================================================
// Package : reg_file_pkg
// Brief   : Default geometry shared by the register file and its bench.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int unsigned c_REG_DATA_WIDTH = 32;
  localparam int unsigned c_REG_SEL_BITS   = 5;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Brief  : 2-read / 1-write register file, combinational reads, entry 0 reads zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = c_REG_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS   = c_REG_SEL_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_SEL_BITS-1:0]   read_sel1,
  input  logic [REG_SEL_BITS-1:0]   read_sel2,
  input  logic                      wEn,
  input  logic [REG_SEL_BITS-1:0]   write_sel,
  input  logic [REG_DATA_WIDTH-1:0] write_data,
  output logic [REG_DATA_WIDTH-1:0] read_data1,
  output logic [REG_DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned c_NUM_REGS = 2 ** REG_SEL_BITS;

  logic [REG_DATA_WIDTH-1:0] r_regs [0:c_NUM_REGS-1];
  logic                      w_wr_ok;
  logic [REG_DATA_WIDTH-1:0] w_rd1;
  logic [REG_DATA_WIDTH-1:0] w_rd2;

  // Entry 0 is never written, so it keeps its reset value of zero.
  assign w_wr_ok = wEn && (write_sel != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[write_sel] <= write_data;
    end
  end

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (read_sel1 != '0) w_rd1 = r_regs[read_sel1];
    if (read_sel2 != '0) w_rd2 = r_regs[read_sel2];
  end

  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;

endmodule : reg_file

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module : tb_reg_file
// Brief  : Directed + randomized checks of reg_file against an array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;
  import reg_file_pkg::*;

  localparam int unsigned W    = c_REG_DATA_WIDTH;
  localparam int unsigned S    = c_REG_SEL_BITS;
  localparam int unsigned NREG = 2 ** S;

  logic         clock;
  logic         reset;
  logic [S-1:0] read_sel1;
  logic [S-1:0] read_sel2;
  logic         wEn;
  logic [S-1:0] write_sel;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data1;
  logic [W-1:0] read_data2;

  logic [W-1:0] model [NREG];
  int           n_cmp;
  int           n_err;

  reg_file #(
    .REG_DATA_WIDTH (W),
    .REG_SEL_BITS   (S)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .read_sel1  (read_sel1),
    .read_sel2  (read_sel2),
    .wEn        (wEn),
    .write_sel  (write_sel),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [S-1:0] sel);
    return (sel == '0) ? '0 : model[sel];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  // Selects both ports and compares against the model after settling.
  task automatic check_reads(input string tag, input logic [S-1:0] s1, input logic [S-1:0] s2);
    read_sel1 = s1;
    read_sel2 = s2;
    #1;
    check({tag, "_rd1"}, read_data1, exp_rd(s1));
    check({tag, "_rd2"}, read_data2, exp_rd(s2));
  endtask

  task automatic write_reg(input logic [S-1:0] sel, input logic [W-1:0] data);
    @(negedge clock);
    wEn        = 1'b1;
    write_sel  = sel;
    write_data = data;
    @(posedge clock);
    if (reset && sel != '0) model[sel] = data;
    #1;
    wEn = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    wEn        = 1'b0;
    write_sel  = '0;
    write_data = '0;
    read_sel1  = '0;
    read_sel2  = '0;
    clear_model();

    // Reset phase
    #10;
    reset = 1'b1;
    check_reads("reset_state", 5'd4, 5'd17);

    // Basic writes and dual-port reads, with literal expectations
    write_reg(5'd1, 32'h2);
    write_reg(5'd3, 32'h5);
    write_reg(5'd7, 32'h9);
    read_sel1 = 5'd3; read_sel2 = 5'd1; #1;
    check("rd_reg3", read_data1, 32'h5);
    check("rd_reg1", read_data2, 32'h2);
    read_sel1 = 5'd7; read_sel2 = 5'd7; #1;
    check("same_idx_rd1", read_data1, 32'h9);
    check("same_idx_rd2", read_data2, 32'h9);

    // Writes to entry 0 are dropped
    write_reg(5'd0, 32'h7);
    read_sel1 = 5'd0; #1;
    check("reg0_zero", read_data1, 32'h0);

    // No bypass: old value before the edge, new value right after it
    write_reg(5'd5, 32'h3);
    @(negedge clock);
    read_sel1 = 5'd5; read_sel2 = 5'd5;
    wEn = 1'b1; write_sel = 5'd5; write_data = 32'hA;
    #1;
    check("no_bypass_pre", read_data1, 32'h3);
    @(posedge clock); #1;
    check("post_edge", read_data1, 32'hA);
    @(negedge clock);
    wEn = 1'b0; write_data = 32'hB;
    @(posedge clock); #1;
    check("wen0_hold_rd1", read_data1, 32'hA);
    check("wen0_hold_rd2", read_data2, 32'hA);
    model[5] = 32'hA;

    // Asynchronous reset between edges, then writes suppressed while low
    @(negedge clock); #2;
    reset = 1'b0;
    clear_model();
    check_reads("async_rst", 5'd1, 5'd7);
    wEn = 1'b1; write_sel = 5'd3; write_data = 32'h55;
    @(posedge clock); #1;
    check_reads("wr_in_rst", 5'd3, 5'd5);
    @(negedge clock);
    wEn = 1'b0; reset = 1'b1;
    check_reads("post_rst_reg1", 5'd1, 5'd3);
    write_reg(5'd1, 32'h33);
    read_sel1 = 5'd1; #1;
    check("rewrite_reg1", read_data1, 32'h33);

    // Randomized traffic with occasional asynchronous resets
    for (int it = 0; it < 400; it++) begin
      @(negedge clock);
      if (!reset) reset = 1'b1;
      wEn        = ($urandom_range(0, 3) != 0);
      write_sel  = S'($urandom);
      write_data = W'($urandom);
      check_reads("rnd_pre", S'($urandom), ($urandom_range(0, 7) == 0) ? write_sel : S'($urandom));
      @(posedge clock);
      if (reset && wEn && write_sel != '0) model[write_sel] = write_data;
      #1;
      check_reads("rnd_post", write_sel, S'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b0;
        clear_model();
        check_reads("rnd_rst", S'($urandom), S'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file

`default_nettype wire
